seq_restoring_divider: RTL and testbench

//   Sequential unsigned restoring divider: the inverse companion of the shift-add

---
 rtl/div_pkg.sv | 12 +
 rtl/div_datapath.sv | 97 +++++++++
 rtl/seq_restoring_divider.sv | 143 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and default width for the restoring divider
package div_pkg;

    localparam int N_DEFAULT = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TEST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/div_datapath.sv
// rtl/div_datapath.sv - A/Q/M/count registers and N+1-bit add/subtract for the divider
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   load                 latch A=0, Q=dividend, M={0,divisor}, count=N
//   shift_sub            shift {A,Q} left one bit and subtract M from A
//   test                 restore A if negative, set quotient bit, decrement count
//   dividend, divisor    operands, used only with load
//   a_sign               sign of the partial remainder A
//   count_is_one         current TEST handles the last quotient bit
//   m_is_zero            latched divisor is zero
//   q_val                current Q register (dividend while in LOAD)
//   quot_next            Q as it will be after the current TEST
//   rem_next             A[N-1:0] as it will be after the current TEST
module div_datapath
    import div_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift_sub,
    input  logic         test,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         a_sign,
    output logic         count_is_one,
    output logic         m_is_zero,
    output logic [N-1:0] q_val,
    output logic [N-1:0] quot_next,
    output logic [N-1:0] rem_next
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N:0]    m_q, m_d;
    logic [CW-1:0] count_q, count_d;

    logic [N:0]    a_restored;
    logic [N:0]    a_shifted;
    logic [N-1:0]  q_shifted;

    // A is always < M before a shift, so 2A+1 < 2^(N+1) and the dropped
    // top bit of {A,Q} is always zero.
    assign {a_shifted, q_shifted} = {a_q[N-1:0], q_q, 1'b0};
    assign a_restored = a_q + m_q;

    always_comb begin
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        count_d = count_q;
        if (load) begin
            a_d     = '0;
            q_d     = dividend;
            m_d     = {1'b0, divisor};
            count_d = CNT_INIT;
        end else if (shift_sub) begin
            a_d = a_shifted - m_q;
            q_d = q_shifted;
        end else if (test) begin
            if (a_q[N]) begin
                a_d = a_restored;
            end
            q_d     = quot_next;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
        end else begin
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
        end
    end

    assign a_sign       = a_q[N];
    assign count_is_one = (count_q == CNT_ONE);
    assign m_is_zero    = (m_q == '0);
    assign q_val        = q_q;
    // A negative trial subtraction means the divisor did not fit: bit is 0.
    assign quot_next    = {q_q[N-1:1], ~a_q[N]};
    assign rem_next     = a_q[N] ? a_restored[N-1:0] : a_q[N-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per two cycles
//
// Ports:
//   d_clk, d_reset              clock, synchronous active-high reset
//   d_start                     request, sampled only while idle
//   d_dividend, d_divisor       operands, sampled with the accepted start
//   d_quotient, d_remainder     registered results, held until the next completion
//   d_div_by_zero               registered divide-by-zero flag, held likewise
//   d_busy                      high whenever not idle
//   d_done                      one-cycle completion pulse
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         d_clk,
    input  logic         d_reset,
    input  logic         d_start,
    input  logic [N-1:0] d_dividend,
    input  logic [N-1:0] d_divisor,
    output logic [N-1:0] d_quotient,
    output logic [N-1:0] d_remainder,
    output logic         d_div_by_zero,
    output logic         d_busy,
    output logic         d_done
);

    logic [2:0]   state_q, state_d;
    logic [N-1:0] quot_q, quot_d;
    logic [N-1:0] rem_q, rem_d;
    logic         dbz_q, dbz_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         load;
    logic         shift_sub;
    logic         test;
    logic         a_sign;
    logic         count_is_one;
    logic         m_is_zero;
    logic [N-1:0] q_val;
    logic [N-1:0] quot_next;
    logic [N-1:0] rem_next;

    div_datapath #(.N(N)) u_datapath (
        .clk          (d_clk),
        .reset        (d_reset),
        .load         (load),
        .shift_sub    (shift_sub),
        .test         (test),
        .dividend     (d_dividend),
        .divisor      (d_divisor),
        .a_sign       (a_sign),
        .count_is_one (count_is_one),
        .m_is_zero    (m_is_zero),
        .q_val        (q_val),
        .quot_next    (quot_next),
        .rem_next     (rem_next)
    );

    always_comb begin
        state_d   = state_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        load      = 1'b0;
        shift_sub = 1'b0;
        test      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (d_start) begin
                    load    = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (m_is_zero) begin
                    // Q still holds the dividend here, so it becomes the remainder.
                    state_d = S_DONE;
                    quot_d  = '1;
                    rem_d   = q_val;
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_sub = 1'b1;
                state_d   = S_TEST;
            end
            S_TEST: begin
                test = 1'b1;
                if (count_is_one) begin
                    state_d = S_DONE;
                    quot_d  = quot_next;
                    rem_d   = rem_next;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge d_clk) begin
        if (d_reset) begin
            state_q <= S_IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign d_quotient    = quot_q;
    assign d_remainder   = rem_q;
    assign d_div_by_zero = dbz_q;
    assign d_busy        = busy_q;
    assign d_done        = done_q;

    // a_sign is consumed inside the datapath through quot_next/rem_next.
    logic unused_sign;
    assign unused_sign = a_sign;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed and random self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

    logic       d_clk = 1'b0;
    logic       d_reset;
    logic       d_start;
    logic [7:0] d_dividend;
    logic [7:0] d_divisor;
    logic [7:0] d_quotient;
    logic [7:0] d_remainder;
    logic       d_div_by_zero;
    logic       d_busy;
    logic       d_done;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] prev_q   = 8'd0;
    logic [7:0] prev_r   = 8'd0;
    logic       prev_dbz = 1'b0;

    seq_restoring_divider #(.N(8)) dut (
        .d_clk         (d_clk),
        .d_reset       (d_reset),
        .d_start       (d_start),
        .d_dividend    (d_dividend),
        .d_divisor     (d_divisor),
        .d_quotient    (d_quotient),
        .d_remainder   (d_remainder),
        .d_div_by_zero (d_div_by_zero),
        .d_busy        (d_busy),
        .d_done        (d_done)
    );

    always #5 d_clk = ~d_clk;

    task automatic tick();
        @(posedge d_clk);
        #1;
    endtask

    // Starts one division and returns after the cycle where d_done is seen.
    // lat counts edges from the accepting edge; held reports whether the
    // outputs kept the previous expected result until done.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output int lat, output bit held);
        held       = 1'b1;
        d_dividend = a;
        d_divisor  = b;
        d_start    = 1'b1;
        tick();
        d_start    = 1'b0;
        d_dividend = 8'($urandom);
        d_divisor  = 8'($urandom);
        lat = 0;
        while (!d_done && lat < 100) begin
            if (d_quotient !== prev_q || d_remainder !== prev_r || d_div_by_zero !== prev_dbz)
                held = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        d_reset = 1'b1;
        d_start = 1'b0;
        d_dividend = 8'd0;
        d_divisor = 8'd0;
        tick();
        tick();
        vec_cnt++;
        if ({d_quotient, d_remainder, d_div_by_zero, d_busy, d_done} !== 19'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got q=%0d r=%0d dbz=%0b busy=%0b done=%0b expected all 0",
                     d_quotient, d_remainder, d_div_by_zero, d_busy, d_done);
        end
        d_reset = 1'b0;
        tick();
        vec_cnt++;
        if (d_busy !== 1'b0 || d_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_after_reset: got busy=%0b done=%0b expected 0 0", d_busy, d_done);
        end
    endtask

    task automatic test_basic();
        int lat;
        bit held;
        run_div(8'd100, 8'd7, lat, held);
        vec_cnt++;
        if (lat !== 17) begin
            err_cnt++;
            $display("FAIL basic_latency: got %0d expected 17", lat);
        end
        vec_cnt++;
        if (d_quotient !== 8'd14 || d_remainder !== 8'd2 || d_div_by_zero !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_100_7: got q=%0d r=%0d dbz=%0b expected q=14 r=2 dbz=0",
                     d_quotient, d_remainder, d_div_by_zero);
        end
        vec_cnt++;
        if (!held) begin
            err_cnt++;
            $display("FAIL basic_hold: got outputs changed before done expected held");
        end
        tick();
        vec_cnt++;
        if (d_done !== 1'b0 || d_busy !== 1'b0 || d_quotient !== 8'd14 || d_remainder !== 8'd2) begin
            err_cnt++;
            $display("FAIL basic_done_width: got done=%0b busy=%0b q=%0d r=%0d expected 0 0 14 2",
                     d_done, d_busy, d_quotient, d_remainder);
        end
        prev_q = 8'd14; prev_r = 8'd2; prev_dbz = 1'b0;
    endtask

    task automatic test_vectors();
        logic [7:0] va [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
        logic [7:0] vb [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
        logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd1,   8'd0};
        logic [7:0] er [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
        int lat;
        bit held;
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], lat, held);
            vec_cnt++;
            if (lat !== 17 || d_quotient !== eq[i] || d_remainder !== er[i] ||
                d_div_by_zero !== 1'b0 || !held) begin
                err_cnt++;
                $display("FAIL vector_%0d_%0d: got q=%0d r=%0d dbz=%0b lat=%0d held=%0b expected q=%0d r=%0d dbz=0 lat=17 held=1",
                         va[i], vb[i], d_quotient, d_remainder, d_div_by_zero, lat, held, eq[i], er[i]);
            end
            prev_q = eq[i]; prev_r = er[i]; prev_dbz = 1'b0;
            tick();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        bit held;
        run_div(8'd200, 8'd0, lat, held);
        vec_cnt++;
        if (lat !== 1) begin
            err_cnt++;
            $display("FAIL dbz_latency: got %0d expected 1", lat);
        end
        vec_cnt++;
        if (d_quotient !== 8'd255 || d_remainder !== 8'd200 || d_div_by_zero !== 1'b1) begin
            err_cnt++;
            $display("FAIL dbz_200_0: got q=%0d r=%0d dbz=%0b expected q=255 r=200 dbz=1",
                     d_quotient, d_remainder, d_div_by_zero);
        end
        prev_q = 8'd255; prev_r = 8'd200; prev_dbz = 1'b1;
        tick();
        vec_cnt++;
        if (d_done !== 1'b0 || d_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL dbz_return_idle: got done=%0b busy=%0b expected 0 0", d_done, d_busy);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        d_dividend = 8'd100;
        d_divisor  = 8'd7;
        d_start    = 1'b1;
        tick();
        lat = 0;
        while (!d_done && lat < 100) begin
            if (lat == 3) begin
                d_start = 1'b1; d_dividend = 8'd9; d_divisor = 8'd3;
            end else begin
                d_start = 1'b0;
            end
            tick();
            lat++;
        end
        vec_cnt++;
        if (lat !== 17 || d_quotient !== 8'd14 || d_remainder !== 8'd2 || d_div_by_zero !== 1'b0) begin
            err_cnt++;
            $display("FAIL ignore_busy_start: got q=%0d r=%0d dbz=%0b lat=%0d expected q=14 r=2 dbz=0 lat=17",
                     d_quotient, d_remainder, d_div_by_zero, lat);
        end
        // Start held during the S_DONE cycle must not launch a new operation.
        d_start = 1'b1; d_dividend = 8'd9; d_divisor = 8'd3;
        tick();
        d_start = 1'b0;
        tick();
        vec_cnt++;
        if (d_busy !== 1'b0 || d_done !== 1'b0 || d_quotient !== 8'd14 || d_remainder !== 8'd2) begin
            err_cnt++;
            $display("FAIL ignore_done_start: got busy=%0b done=%0b q=%0d r=%0d expected 0 0 14 2",
                     d_busy, d_done, d_quotient, d_remainder);
        end
        prev_q = 8'd14; prev_r = 8'd2; prev_dbz = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit held;
        d_dividend = 8'd100;
        d_divisor  = 8'd7;
        d_start    = 1'b1;
        tick();
        d_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        d_reset = 1'b1;
        tick();
        vec_cnt++;
        if ({d_quotient, d_remainder, d_div_by_zero, d_busy, d_done} !== 19'd0) begin
            err_cnt++;
            $display("FAIL reset_mid_op: got q=%0d r=%0d dbz=%0b busy=%0b done=%0b expected all 0",
                     d_quotient, d_remainder, d_div_by_zero, d_busy, d_done);
        end
        d_reset = 1'b0;
        prev_q = 8'd0; prev_r = 8'd0; prev_dbz = 1'b0;
        tick();
        run_div(8'd12, 8'd4, lat, held);
        vec_cnt++;
        if (lat !== 17 || d_quotient !== 8'd3 || d_remainder !== 8'd0 || d_div_by_zero !== 1'b0 || !held) begin
            err_cnt++;
            $display("FAIL after_reset_12_4: got q=%0d r=%0d dbz=%0b lat=%0d held=%0b expected q=3 r=0 dbz=0 lat=17 held=1",
                     d_quotient, d_remainder, d_div_by_zero, lat, held);
        end
        prev_q = 8'd3; prev_r = 8'd0; prev_dbz = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] a, b, eq, er;
        logic edbz;
        int elat, lat;
        bit held;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (b == 8'd0) begin
                eq = 8'd255; er = a; edbz = 1'b1; elat = 1;
            end else begin
                eq = a / b; er = a % b; edbz = 1'b0; elat = 17;
            end
            run_div(a, b, lat, held);
            vec_cnt++;
            if (lat !== elat || d_quotient !== eq || d_remainder !== er ||
                d_div_by_zero !== edbz || !held) begin
                err_cnt++;
                $display("FAIL random_%0d_%0d: got q=%0d r=%0d dbz=%0b lat=%0d held=%0b expected q=%0d r=%0d dbz=%0b lat=%0d held=1",
                         a, b, d_quotient, d_remainder, d_div_by_zero, lat, held, eq, er, edbz, elat);
            end
            prev_q = eq; prev_r = er; prev_dbz = edbz;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
